sram_req_arbiter: RTL

//  Shares one downstream SRAM-like memory port between the IF-stage inst_sram master and the MEM-stage data_sram master.

---
 rtl/sram_req_arbiter_pkg.sv | 32 +++
 rtl/sram_req_arbiter_if.sv | 25 ++
 rtl/sram_req_arbiter_id_fifo.sv | 53 +++++
 rtl/sram_req_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared types, ids and the arbitration helper for the inst/data SRAM request arbiter.
package sram_req_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // On a tie, fixed priority gives data; otherwise the round-robin pointer names the favoured master.
  function automatic logic arb_pick(input logic inst_req, input logic data_req,
                                    input logic prio_data, input logic rr_fav);
    if (inst_req && data_req) begin
      return prio_data ? ID_DATA : rr_fav;
    end
    return data_req ? ID_DATA : ID_INST;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// One SRAM-like request/response port; master drives the request, slave answers.
interface sram_req_arbiter_if;
  import sram_req_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order queue of issuer ids for accepted-but-unanswered transactions.
// Push is ignored when full and pop when empty; count is exact and pointers wrap naturally.
module sram_req_arbiter_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem_q[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one downstream SRAM port between the inst and data masters, locking the grant until
// addr_ok and steering each in-order response back to its issuer.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OST_DEPTH = 4,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master mem,
  output logic               ost_err
);

  lock_state_t state;
  logic        lock_id;
  logic        rr_ptr;
  logic        sel_id;
  logic        sel_req;
  logic        issue;
  logic        accept;
  logic        pop;
  logic        full;
  logic        empty;
  logic        head;
  mem_cmd_t    inst_cmd;
  mem_cmd_t    data_cmd;
  mem_cmd_t    sel_cmd;

  assign inst_cmd = '{wr: inst.wr, size: inst.size, wstrb: inst.wstrb,
                      addr: inst.addr, wdata: inst.wdata};
  assign data_cmd = '{wr: data.wr, size: data.size, wstrb: data.wstrb,
                      addr: data.addr, wdata: data.wdata};

  always_comb begin
    sel_id  = (state == ST_LOCK) ? lock_id
                                 : arb_pick(inst.req, data.req, DATA_PRIO, rr_ptr);
    sel_req = (sel_id == ID_DATA) ? data.req : inst.req;
    sel_cmd = (sel_id == ID_DATA) ? data_cmd : inst_cmd;
  end

  // Full is the registered occupancy, so a same-cycle pop never lets a push slip in.
  assign issue  = sel_req & ~full;
  assign accept = issue & mem.addr_ok;
  assign pop    = mem.data_ok & ~empty;

  always_comb begin
    mem.req   = 1'b0;
    mem.wr    = 1'b0;
    mem.size  = '0;
    mem.wstrb = '0;
    mem.addr  = '0;
    mem.wdata = '0;
    if (resetn) begin
      mem.req   = issue;
      mem.wr    = sel_cmd.wr;
      mem.size  = sel_cmd.size;
      mem.wstrb = sel_cmd.wstrb;
      mem.addr  = sel_cmd.addr;
      mem.wdata = sel_cmd.wdata;
    end
  end

  always_comb begin
    inst.addr_ok = resetn & accept & (sel_id == ID_INST);
    data.addr_ok = resetn & accept & (sel_id == ID_DATA);
    inst.data_ok = resetn & pop & (head == ID_INST);
    data.data_ok = resetn & pop & (head == ID_DATA);
    inst.rdata   = resetn ? mem.rdata : '0;
    data.rdata   = resetn ? mem.rdata : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      lock_id <= ID_INST;
      rr_ptr  <= ID_INST;
      ost_err <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= ~sel_id;
      end
      if (mem.data_ok && empty) begin
        ost_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (issue && !mem.addr_ok) begin
            state   <= ST_LOCK;
            lock_id <= sel_id;
          end
        end
        ST_LOCK: begin
          // Held while the queue is full; released on acceptance or when the master withdraws.
          if (accept || !sel_req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sram_req_arbiter_id_fifo #(
    .WIDTH (1),
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_dat (sel_id),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

endmodule
